// File: rtl/bus_stable_filter_if.sv
// Bus bundle between the destination-domain synchronizer and bus_stable_filter.
// The master drives the synchronized bus and the reject-counter clear. The slave returns the qualified bus.
interface bus_stable_filter_if #(
  parameter int Bus_BW = 4
);
  logic [Bus_BW-1:0] Bus_sync;
  logic              rej_clr;
  logic [Bus_BW-1:0] Bus_out;
  logic              upd;
  logic [7:0]        rej_cnt;

  modport master (
    output Bus_sync,
    output rej_clr,
    input  Bus_out,
    input  upd,
    input  rej_cnt
  );

  modport slave (
    input  Bus_sync,
    input  rej_clr,
    output Bus_out,
    output upd,
    output rej_cnt
  );
endinterface

// File: rtl/bus_stable_filter.sv
// Passes a synchronized multi-bit bus only after it holds one value for STABLE_CNT
// dest_clk samples. Mixed-bit transients are dropped, and each one is counted in rej_cnt.
module bus_stable_filter #(
  parameter int                Bus_BW     = 4,
  parameter int                STABLE_CNT = 3,
  parameter logic [Bus_BW-1:0] RST_VAL    = {Bus_BW{1'b0}}
) (
  input  logic               dest_clk,
  input  logic               dest_rst,
  bus_stable_filter_if.slave bus
);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_QUAL   = 1'b1;

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

  logic [0:0]        state_p0;
  logic [Bus_BW-1:0] cand_p0;
  logic [3:0]        cnt_p0;
  logic [Bus_BW-1:0] bus_out_p0;
  logic              upd_p0;
  logic [7:0]        rej_cnt_p0;

  logic              same_cand;
  logic              same_out;
  logic              reject;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign same_cand = (bus.Bus_sync == cand_p0);
  assign same_out  = (bus.Bus_sync == bus_out_p0);
  assign reject    = (state_p0 == ST_QUAL) && !same_cand;

  // Stage p0: qualification FSM, candidate tracking and registered outputs
  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      state_p0   <= ST_STABLE;
      cand_p0    <= RST_VAL;
      cnt_p0     <= 4'd0;
      bus_out_p0 <= RST_VAL;
      upd_p0     <= 1'b0;
    end else begin
      upd_p0 <= 1'b0;
      case (state_p0)
        ST_STABLE: begin
          if (!same_out) begin
            cand_p0  <= bus.Bus_sync;
            cnt_p0   <= 4'd1;
            state_p0 <= ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (same_cand) begin
            if (cnt_p0 == CNT_LAST) begin
              bus_out_p0 <= cand_p0;
              upd_p0     <= 1'b1;
              cnt_p0     <= 4'd0;
              state_p0   <= ST_STABLE;
            end else begin
              cnt_p0 <= cnt_p0 + 4'd1;
            end
          end else if (same_out) begin
            // The transient settled back to the value already on Bus_out.
            cnt_p0   <= 4'd0;
            state_p0 <= ST_STABLE;
          end else begin
            cand_p0 <= bus.Bus_sync;
            cnt_p0  <= 4'd1;
          end
        end
        default: begin
          state_p0 <= ST_STABLE;
          cnt_p0   <= 4'd0;
        end
      endcase
    end
  end

  // Stage p0: reject counter; a clear beats a reject on the same edge
  always_ff @(posedge dest_clk) begin
    if (dest_rst || bus.rej_clr) begin
      rej_cnt_p0 <= 8'd0;
    end else if (reject) begin
      rej_cnt_p0 <= sat_inc8(rej_cnt_p0);
    end
  end

  assign bus.Bus_out = bus_out_p0;
  assign bus.upd     = upd_p0;
  assign bus.rej_cnt = rej_cnt_p0;

endmodule

// File: tb/tb_bus_stable_filter.sv
// Directed bench for bus_stable_filter covering reset, qualification, glitch rejection,
// reject-counter saturation and clear, reset during qualification, and back-to-back updates.
module tb_bus_stable_filter;

  logic dest_clk = 1'b0;
  logic dest_rst;
  int   total = 0;
  int   bad   = 0;

  bus_stable_filter_if #(.Bus_BW(4)) bif ();

  bus_stable_filter #(
    .Bus_BW     (4),
    .STABLE_CNT (3),
    .RST_VAL    (4'b0000)
  ) dut (
    .dest_clk (dest_clk),
    .dest_rst (dest_rst),
    .bus      (bif.slave)
  );

  always #5 dest_clk = ~dest_clk;

  // Sets the inputs, lets one rising edge sample them, and returns at the following falling edge.
  task automatic apply(input logic [3:0] v);
    bif.Bus_sync = v;
    @(negedge dest_clk);
  endtask

  task automatic test_reset;
    dest_rst = 1'b1;
    apply(4'b1010);
    apply(4'b1010);
    total++; if (bif.Bus_out !== 4'b0000) begin bad++; $display("FAIL rst_out got=%b exp=0000", bif.Bus_out); end
    total++; if (bif.upd !== 1'b0) begin bad++; $display("FAIL rst_upd got=%b exp=0", bif.upd); end
    total++; if (bif.rej_cnt !== 8'd0) begin bad++; $display("FAIL rst_rej got=%0d exp=0", bif.rej_cnt); end
    dest_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(4'b0000);
      total++; if (bif.upd !== 1'b0 || bif.Bus_out !== 4'b0000) begin
        bad++; $display("FAIL rst_release cyc=%0d upd=%b out=%b exp upd=0 out=0000", i, bif.upd, bif.Bus_out);
      end
    end
  endtask

  task automatic test_clean_update;
    apply(4'b0111);
    apply(4'b0111);
    total++; if (bif.Bus_out !== 4'b0000 || bif.upd !== 1'b0) begin
      bad++; $display("FAIL clean_early out=%b upd=%b exp out=0000 upd=0", bif.Bus_out, bif.upd);
    end
    apply(4'b0111);
    total++; if (bif.Bus_out !== 4'b0111 || bif.upd !== 1'b1) begin
      bad++; $display("FAIL clean_accept out=%b upd=%b exp out=0111 upd=1", bif.Bus_out, bif.upd);
    end
    apply(4'b0111);
    total++; if (bif.upd !== 1'b0 || bif.Bus_out !== 4'b0111) begin
      bad++; $display("FAIL clean_after out=%b upd=%b exp out=0111 upd=0", bif.Bus_out, bif.upd);
    end
    total++; if (bif.rej_cnt !== 8'd0) begin bad++; $display("FAIL clean_rej got=%0d exp=0", bif.rej_cnt); end
  endtask

  task automatic test_skew_glitch;
    int          pulses;
    logic [3:0]  seq [5];
    pulses = 0;
    seq = '{4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      if (bif.upd === 1'b1) pulses++;
      total++; if (bif.Bus_out === 4'b1111) begin bad++; $display("FAIL glitch_leak cyc=%0d got=%b", i, bif.Bus_out); end
      if (i == 1) begin
        total++; if (bif.rej_cnt !== 8'd1) begin bad++; $display("FAIL glitch_rej_timing got=%0d exp=1", bif.rej_cnt); end
      end
      if (i == 3) begin
        total++; if (bif.Bus_out !== 4'b1000 || bif.upd !== 1'b1) begin
          bad++; $display("FAIL glitch_accept out=%b upd=%b exp out=1000 upd=1", bif.Bus_out, bif.upd);
        end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
    total++; if (bif.rej_cnt !== 8'd1) begin bad++; $display("FAIL glitch_rej got=%0d exp=1", bif.rej_cnt); end
  endtask

  task automatic test_return_old;
    int          pulses;
    logic [3:0]  seq [5];
    pulses = 0;
    seq = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      if (bif.upd === 1'b1) pulses++;
      total++; if (bif.Bus_out !== 4'b1000) begin bad++; $display("FAIL return_out cyc=%0d got=%b exp=1000", i, bif.Bus_out); end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL return_pulses got=%0d exp=0", pulses); end
    total++; if (bif.rej_cnt !== 8'd2) begin bad++; $display("FAIL return_rej got=%0d exp=2", bif.rej_cnt); end
  endtask

  task automatic test_saturation_clear;
    int pulses;
    pulses = 0;
    // Two rejects already counted; 253 more reach 255 exactly.
    for (int i = 0; i < 253; i++) begin
      apply((i % 2 == 0) ? 4'b0001 : 4'b1001);
      if (bif.upd === 1'b1) pulses++;
      apply(4'b1000);
      if (bif.upd === 1'b1) pulses++;
    end
    total++; if (bif.rej_cnt !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d exp=255", bif.rej_cnt); end
    for (int i = 0; i < 47; i++) begin
      apply(4'b0001);
      if (bif.upd === 1'b1) pulses++;
      apply(4'b1000);
      if (bif.upd === 1'b1) pulses++;
    end
    total++; if (bif.rej_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", bif.rej_cnt); end
    total++; if (pulses != 0 || bif.Bus_out !== 4'b1000) begin
      bad++; $display("FAIL sat_out pulses=%0d out=%b exp pulses=0 out=1000", pulses, bif.Bus_out);
    end
    apply(4'b0001);
    bif.rej_clr = 1'b1;
    apply(4'b1000);
    bif.rej_clr = 1'b0;
    total++; if (bif.rej_cnt !== 8'd0) begin bad++; $display("FAIL clr_vs_reject got=%0d exp=0", bif.rej_cnt); end
    apply(4'b0011);
    apply(4'b1000);
    total++; if (bif.rej_cnt !== 8'd1) begin bad++; $display("FAIL count_after_clr got=%0d exp=1", bif.rej_cnt); end
  endtask

  task automatic test_reset_mid_qual;
    int pulses;
    pulses = 0;
    apply(4'b0101);
    apply(4'b0101);
    dest_rst = 1'b1;
    apply(4'b0101);
    if (bif.upd === 1'b1) pulses++;
    total++; if (bif.Bus_out !== 4'b0000 || bif.rej_cnt !== 8'd0) begin
      bad++; $display("FAIL midrst_state out=%b rej=%0d exp out=0000 rej=0", bif.Bus_out, bif.rej_cnt);
    end
    dest_rst = 1'b0;
    apply(4'b0101);
    if (bif.upd === 1'b1) pulses++;
    apply(4'b0101);
    if (bif.upd === 1'b1) pulses++;
    total++; if (pulses != 0 || bif.Bus_out !== 4'b0000) begin
      bad++; $display("FAIL midrst_early pulses=%0d out=%b exp pulses=0 out=0000", pulses, bif.Bus_out);
    end
    apply(4'b0101);
    total++; if (bif.Bus_out !== 4'b0101 || bif.upd !== 1'b1) begin
      bad++; $display("FAIL midrst_accept out=%b upd=%b exp out=0101 upd=1", bif.Bus_out, bif.upd);
    end
    total++; if (bif.rej_cnt !== 8'd0) begin bad++; $display("FAIL midrst_rej got=%0d exp=0", bif.rej_cnt); end
  endtask

  // Entered on the falling edge right after an acceptance, so the first new sample has no gap.
  task automatic test_back_to_back;
    apply(4'b0110);
    total++; if (bif.upd !== 1'b0 || bif.Bus_out !== 4'b0101) begin
      bad++; $display("FAIL b2b_first out=%b upd=%b exp out=0101 upd=0", bif.Bus_out, bif.upd);
    end
    apply(4'b0110);
    apply(4'b0110);
    total++; if (bif.Bus_out !== 4'b0110 || bif.upd !== 1'b1) begin
      bad++; $display("FAIL b2b_accept1 out=%b upd=%b exp out=0110 upd=1", bif.Bus_out, bif.upd);
    end
    apply(4'b1001);
    total++; if (bif.upd !== 1'b0) begin bad++; $display("FAIL b2b_gap upd=%b exp=0", bif.upd); end
    apply(4'b1001);
    apply(4'b1001);
    total++; if (bif.Bus_out !== 4'b1001 || bif.upd !== 1'b1) begin
      bad++; $display("FAIL b2b_accept2 out=%b upd=%b exp out=1001 upd=1", bif.Bus_out, bif.upd);
    end
    total++; if (bif.rej_cnt !== 8'd0) begin bad++; $display("FAIL b2b_rej got=%0d exp=0", bif.rej_cnt); end
  endtask

  initial begin
    dest_rst     = 1'b1;
    bif.Bus_sync = 4'b1010;
    bif.rej_clr  = 1'b0;
    @(negedge dest_clk);
    test_reset();
    test_clean_update();
    test_skew_glitch();
    test_return_old();
    test_saturation_clear();
    test_reset_mid_qual();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
